// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_pkg
// Purpose  : Shared definitions for the TPU tile sequencer: FSM state
//            encoding and the default result-pipeline latency expression.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLOAD  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

  // A row entering the array needs one pass through the rows and one pass
  // through the columns before its result reaches the result SRAM.
  localparam int PIPE_LAT_FACTOR = 2;

  function automatic int default_pipe_lat(input int matrix_size);
    return PIPE_LAT_FACTOR * matrix_size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_strobe_delay.sv
`default_nettype none
// ============================================================================
// Module   : tpu_strobe_delay
// Purpose  : Fixed-depth shift register delaying a 1-bit strobe by DEPTH
//            clock cycles, with synchronous clear.
// Ports    : clk     - clock
//            rst     - synchronous active-high clear of every stage
//            din     - strobe in
//            dout    - strobe delayed by exactly DEPTH cycles
//            pending - 1 while any stage still holds a strobe
// Revision : 1.0 - initial release
// ============================================================================
module tpu_strobe_delay #(
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic pending
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= din;
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout    = sr[DEPTH-1];
  assign pending = |sr;

endmodule
`default_nettype wire

// File: rtl/tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tpu_tile_sequencer
// Purpose  : Sequences a matrix job over tile_cnt tiles: reloads weights per
//            tile, streams MATRIX_SIZE unified-buffer rows per tile, and
//            writes the matching result rows PIPE_LAT cycles later.
// Ports    : clk, rst (sync, active-high)
//            start, ub_base, res_base, w_base, tile_cnt  - job request
//            ub_re/ub_addr   - unified-buffer read
//            w_addr/we_rl    - weight slot and reload pulse
//            res_we/res_addr - result-SRAM write
//            busy, done, err_busy - status
//            cycle_cnt (only with TPU_SEQ_PERF_CNT_EN) - busy-cycle counter
// Config   : `define TPU_SEQ_PERF_CNT_EN to add the cycle_cnt counter/port.
// Note     : all outputs are registered, so they appear one cycle after the
//            FSM enters the state that produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tpu_tile_sequencer
  import tpu_pkg::*;
#(
  parameter int MATRIX_SIZE = 16,
  parameter int ADDR_W      = 10,
  parameter int WADDR_W     = 2,
  parameter int PIPE_LAT    = default_pipe_lat(MATRIX_SIZE),
  parameter int TILE_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  ub_base,
  input  logic [ADDR_W-1:0]  res_base,
  input  logic [WADDR_W-1:0] w_base,
  input  logic [TILE_W-1:0]  tile_cnt,
  output logic               ub_re,
  output logic [ADDR_W-1:0]  ub_addr,
  output logic [WADDR_W-1:0] w_addr,
  output logic               we_rl,
  output logic               res_we,
  output logic [ADDR_W-1:0]  res_addr,
  output logic               busy,
  output logic               done,
`ifdef TPU_SEQ_PERF_CNT_EN
  output logic [31:0]        cycle_cnt,
`endif
  output logic               err_busy
);

  localparam int ROW_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  seq_state_t state, state_nxt;

  logic [ADDR_W-1:0]  ub_ptr;
  logic [WADDR_W-1:0] w_base_q;
  logic [WADDR_W-1:0] tile_idx;
  logic [TILE_W-1:0]  tiles_left;
  logic [ROW_W-1:0]   row_cnt;

  logic accept;
  logic row_last;
  logic ub_re_nxt, we_rl_nxt, busy_nxt, done_nxt;
  logic dly_pending;
  logic pending;

  assign row_last = (row_cnt == ROW_W'(MATRIX_SIZE - 1));
  // The registered ub_re feeds the delay line, so a strobe still in the
  // output flop counts as pending too.
  assign pending  = dly_pending | ub_re;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ub_re_nxt = 1'b0;
    we_rl_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (tile_cnt == '0) ? ST_DONE : ST_WLOAD;
        end
      end
      ST_WLOAD: begin
        we_rl_nxt = 1'b1;
        busy_nxt  = 1'b1;
        state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        ub_re_nxt = 1'b1;
        busy_nxt  = 1'b1;
        // Next tile's weights load immediately; its results overlap this
        // tile's still-draining results in the delay line.
        if (row_last)
          state_nxt = (tiles_left == TILE_W'(1)) ? ST_DRAIN : ST_WLOAD;
      end
      ST_DRAIN: begin
        busy_nxt = 1'b1;
        if (!pending) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Job context, address counters and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ub_ptr     <= '0;
      w_base_q   <= '0;
      tile_idx   <= '0;
      tiles_left <= '0;
      row_cnt    <= '0;
      ub_re      <= 1'b0;
      ub_addr    <= '0;
      w_addr     <= '0;
      we_rl      <= 1'b0;
      res_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_busy   <= 1'b0;
    end else begin
      ub_re <= ub_re_nxt;
      we_rl <= we_rl_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;

      if (accept) begin
        ub_ptr     <= ub_base;
        w_base_q   <= w_base;
        tile_idx   <= '0;
        tiles_left <= tile_cnt;
        row_cnt    <= '0;
        res_addr   <= res_base;
        err_busy   <= 1'b0;
      end else begin
        if (start && (state != ST_IDLE)) err_busy <= 1'b1;
        // res_addr advances after each written row and wraps naturally.
        if (res_we) res_addr <= res_addr + ADDR_W'(1);
      end

      if (state == ST_WLOAD) w_addr <= w_base_q + tile_idx;

      // ub_ptr is never rewound between tiles, so rows stay contiguous.
      if (state == ST_STREAM) begin
        ub_addr <= ub_ptr;
        ub_ptr  <= ub_ptr + ADDR_W'(1);
        if (row_last) begin
          row_cnt    <= '0;
          tile_idx   <= tile_idx + WADDR_W'(1);
          tiles_left <= tiles_left - TILE_W'(1);
        end else begin
          row_cnt <= row_cnt + ROW_W'(1);
        end
      end
    end
  end

`ifdef TPU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)         cycle_cnt <= '0;
    else if (accept) cycle_cnt <= '0;
    else if (busy)   cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

  // --------------------------------------------------------------------------
  // Result write strobe: ub_re delayed by the array latency
  // --------------------------------------------------------------------------
  tpu_strobe_delay #(
    .DEPTH (PIPE_LAT)
  ) u_strobe_delay (
    .clk     (clk),
    .rst     (rst),
    .din     (ub_re),
    .dout    (res_we),
    .pending (dly_pending)
  );

endmodule
`default_nettype wire

// File: tb/tb_tpu_tile_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tpu_tile_sequencer
// Purpose  : Directed self-checking bench for tpu_tile_sequencer with
//            default parameters (MATRIX_SIZE=16, ADDR_W=10, WADDR_W=2,
//            PIPE_LAT=32, TILE_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_tile_sequencer;

  localparam int MS  = 16;
  localparam int AW  = 10;
  localparam int WW  = 2;
  localparam int TW  = 8;
  localparam int LAT = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] ub_base;
  logic [AW-1:0] res_base;
  logic [WW-1:0] w_base;
  logic [TW-1:0] tile_cnt;
  logic          ub_re;
  logic [AW-1:0] ub_addr;
  logic [WW-1:0] w_addr;
  logic          we_rl;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic          busy;
  logic          done;
  logic          err_busy;
`ifdef TPU_SEQ_PERF_CNT_EN
  logic [31:0]   cycle_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tpu_tile_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ub_base  (ub_base),
    .res_base (res_base),
    .w_base   (w_base),
    .tile_cnt (tile_cnt),
    .ub_re    (ub_re),
    .ub_addr  (ub_addr),
    .w_addr   (w_addr),
    .we_rl    (we_rl),
    .res_we   (res_we),
    .res_addr (res_addr),
    .busy     (busy),
    .done     (done),
`ifdef TPU_SEQ_PERF_CNT_EN
    .cycle_cnt(cycle_cnt),
`endif
    .err_busy (err_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ub_re"},    {31'd0, ub_re},    32'd0);
    chk({tag, "_ub_addr"},  {22'd0, ub_addr},  32'd0);
    chk({tag, "_w_addr"},   {30'd0, w_addr},   32'd0);
    chk({tag, "_we_rl"},    {31'd0, we_rl},    32'd0);
    chk({tag, "_res_we"},   {31'd0, res_we},   32'd0);
    chk({tag, "_res_addr"}, {22'd0, res_addr}, 32'd0);
    chk({tag, "_busy"},     {31'd0, busy},     32'd0);
    chk({tag, "_done"},     {31'd0, done},     32'd0);
    chk({tag, "_err_busy"}, {31'd0, err_busy}, 32'd0);
  endtask

  // Runs one job and checks it. wseq holds the expected w_addr of reload k
  // in bits [2k+1:2k]; inj >= 0 raises a stray start at that cycle.
  task automatic run_job(input string name, input logic [AW-1:0] ub, input logic [AW-1:0] res,
                         input logic [WW-1:0] w, input logic [TW-1:0] tc, input logic [7:0] wseq,
                         input logic [AW-1:0] exp_ub_last, input logic [AW-1:0] exp_res_last,
                         input int exp_rows, input int inj);
    logic [AW-1:0] exp_ub, exp_res, last_ub, last_res;
    int n, n_ub, n_res, n_w, n_done, first_ub, first_res, busy_cyc, tail_evt;
    exp_ub = ub; exp_res = res; last_ub = '0; last_res = '0;
    n_ub = 0; n_res = 0; n_w = 0; n_done = 0; first_ub = -1; first_res = -1;
    busy_cyc = 0; tail_evt = 0;
    ub_base = ub; res_base = res; w_base = w; tile_cnt = tc; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (n_done == 0 && n < 600) begin
      if (ub_re) begin
        chk({name, "_ub_addr"}, {22'd0, ub_addr}, {22'd0, exp_ub});
        if (first_ub < 0) first_ub = n;
        last_ub = ub_addr; exp_ub = exp_ub + 1'b1; n_ub++;
      end
      if (we_rl) begin
        if (n_w < 4) chk({name, "_w_addr"}, {30'd0, w_addr}, {30'd0, wseq[2*n_w +: 2]});
        n_w++;
      end
      if (res_we) begin
        chk({name, "_res_addr"}, {22'd0, res_addr}, {22'd0, exp_res});
        if (first_res < 0) first_res = n;
        last_res = res_addr; exp_res = exp_res + 1'b1; n_res++;
      end
      if (busy) busy_cyc++;
      if (done) begin
        n_done++;
        chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({name, "_res_before_done"}, n_res, exp_rows);
      end
      if (n == inj) begin
        start = 1'b1; ub_base = ~ub; res_base = ~res; tile_cnt = tc + 8'd2;
      end else begin
        start = 1'b0;
      end
      if (n_done == 0) begin
        step();
        n++;
      end
    end
    start = 1'b0;
    chk({name, "_done_seen"}, n_done, 1);
    chk({name, "_ub_rows"}, n_ub, exp_rows);
    chk({name, "_res_rows"}, n_res, exp_rows);
    chk({name, "_reloads"}, n_w, {24'd0, tc});
    chk({name, "_latency"}, first_res - first_ub, LAT);
    chk({name, "_ub_last"}, {22'd0, last_ub}, {22'd0, exp_ub_last});
    chk({name, "_res_last"}, {22'd0, last_res}, {22'd0, exp_res_last});
    chk({name, "_err_busy"}, {31'd0, err_busy}, (inj >= 0) ? 32'd1 : 32'd0);
`ifdef TPU_SEQ_PERF_CNT_EN
    chk({name, "_cycle_cnt"}, cycle_cnt, busy_cyc);
`endif
    for (int k = 0; k < 4; k++) begin
      step();
      tail_evt += int'(done) + int'(res_we) + int'(ub_re) + int'(we_rl) + int'(busy);
    end
    chk({name, "_quiet_after_done"}, tail_evt, 0);
`ifdef TPU_SEQ_PERF_CNT_EN
    chk({name, "_cycle_cnt_hold"}, cycle_cnt, busy_cyc);
`endif
  endtask

  initial begin
    int evt;
    rst = 1'b1; start = 1'b0; ub_base = '0; res_base = '0; w_base = '0; tile_cnt = '0;
    step();
    step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();

    // Single tile: rows 0x010..0x01F, results 0x200..0x20F, slot 2.
    run_job("single", 10'h010, 10'h200, 2'd2, 8'd1, 8'h02, 10'h01F, 10'h20F, MS, -1);

    // Three tiles from slot 3: slots 3,0,1; 48 contiguous rows.
    run_job("three", 10'h040, 10'h100, 2'd3, 8'd3, 8'h13, 10'h06F, 10'h12F, 3*MS, -1);

    // Address wrap on both counters.
    run_job("wrap", 10'h3F8, 10'h3FC, 2'd1, 8'd1, 8'h01, 10'h007, 10'h00B, MS, -1);

    // Stray start during STREAM is ignored but flagged.
    run_job("stray", 10'h010, 10'h200, 2'd0, 8'd1, 8'h00, 10'h01F, 10'h20F, MS, 8);

    // Zero tiles: done two cycles after start, no traffic; start clears err_busy.
    evt = 0;
    tile_cnt = '0; ub_base = 10'h055; res_base = 10'h0AA; w_base = 2'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done_c1", {31'd0, done}, 32'd0);
    chk("zero_err_cleared", {31'd0, err_busy}, 32'd0);
    evt += int'(ub_re) + int'(we_rl) + int'(res_we);
    step();
    chk("zero_done_c2", {31'd0, done}, 32'd1);
    chk("zero_busy_c2", {31'd0, busy}, 32'd0);
    evt += int'(ub_re) + int'(we_rl) + int'(res_we);
    step();
    chk("zero_done_c3", {31'd0, done}, 32'd0);
    evt += int'(ub_re) + int'(we_rl) + int'(res_we);
    chk("zero_no_traffic", evt, 0);
    step();

    // Reset while results are still in flight (DRAIN).
    ub_base = 10'h020; res_base = 10'h300; w_base = 2'd3; tile_cnt = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 25; k++) step();
    chk("drain_busy_before_rst", {31'd0, busy}, 32'd1);
    chk("drain_no_res_yet", {31'd0, res_we}, 32'd0);
    rst = 1'b1;
    step();
    chk_idle_outputs("drain_rst");
    rst = 1'b0;
    evt = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      evt += int'(res_we) + int'(done) + int'(busy);
    end
    chk("drain_no_res_after_rst", evt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tpu_tile_sequencer.md
TPU_TILE_SEQUENCER -- requirements
Module: tpu_tile_sequencer

Interface
REQ-001 SHALL have parameter MATRIX_SIZE, default 16, meaning systolic array dimension (rows per tile).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning unified-buffer and result-SRAM address width.
REQ-003 SHALL have parameter WADDR_W, default 2, meaning weight-buffer address width.
REQ-004 SHALL have parameter PIPE_LAT, default 2*MATRIX_SIZE, meaning cycles from ub_re to matching result row at result SRAM input.
REQ-005 SHALL have parameter TILE_W, default 8, meaning width of the tile-count field.
REQ-006 SHALL have ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request.
- ub_base  in  ADDR_W  first unified-buffer row address.
- res_base  in  ADDR_W  first result-SRAM row address.
- w_base  in  WADDR_W  weight-buffer slot of tile 0.
- tile_cnt  in  TILE_W  number of tiles; 0 means no work.
- ub_re  out  1  unified-buffer read strobe.
- ub_addr  out  ADDR_W  unified-buffer read address.
- w_addr  out  WADDR_W  weight-buffer slot address.
- we_rl  out  1  weight-reload pulse to the systolic array.
- res_we  out  1  result-SRAM write enable.
- res_addr  out  ADDR_W  result-SRAM write address.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- err_busy  out  1  sticky: start seen while busy.

Function
REQ-007 SHALL implement FSM states IDLE, WLOAD, STREAM, DRAIN, DONE.
REQ-008 SHALL, in IDLE with start=1 and tile_cnt>0, latch ub_base, res_base, w_base, tile_cnt and go to WLOAD the next cycle; busy=1 from that cycle.
REQ-009 SHALL, in IDLE with start=1 and tile_cnt=0, go directly to DONE (done pulse, no ub_re, res_we or we_rl).
REQ-010 SHALL, in WLOAD, assert we_rl for exactly one cycle with w_addr = (w_base + tile index) mod 2^WADDR_W, then go to STREAM.
REQ-011 SHALL, in STREAM, assert ub_re for exactly MATRIX_SIZE consecutive cycles, ub_addr incrementing by 1 each cycle, continuing across tiles without reset to ub_base.
REQ-012 SHALL derive res_we as ub_re delayed by exactly PIPE_LAT cycles (shift register); res_addr starts at res_base and increments by 1 after each res_we cycle.
REQ-013 SHALL, after STREAM, go to WLOAD of the next tile if tiles remain, else to DRAIN; weight reload for the next tile SHALL NOT wait for the previous tile's results.
REQ-014 SHALL leave DRAIN when the delay line holds no pending strobe, entering DONE; DONE asserts done for one cycle, deasserts busy the same cycle, and returns to IDLE.
REQ-015 SHALL wrap ub_addr and res_addr modulo 2^ADDR_W without error.
REQ-016 SHALL ignore start outside IDLE and set err_busy, cleared only by rst or by an accepted start in IDLE.
REQ-017 SHALL produce exactly tile_cnt*MATRIX_SIZE res_we cycles per job.

Reset
REQ-018 SHALL, on rst=1 at any clock edge, including mid-job, enter IDLE, clear the delay line and drive ub_re, we_rl, res_we, busy, done, err_busy to 0 and ub_addr, res_addr, w_addr to 0; no res_we SHALL follow reset for an aborted job.

Configuration
REQ-019 SHALL, with macro TPU_SEQ_PERF_CNT_EN defined, add output cycle_cnt (32 bits), cleared on accepted start, incrementing every busy cycle, held after done; without the macro the port and counter SHALL not exist.

Structure
REQ-020 SHALL place the FSM state encoding and default PIPE_LAT expression in shared package tpu_pkg.
REQ-021 SHALL implement the PIPE_LAT strobe delay as sub-module tpu_strobe_delay (parametrised depth, synchronous clear).

Verification
REQ-022 Single tile: MATRIX_SIZE=16, ub_base=0x010, res_base=0x200, tile_cnt=1, start -> we_rl one cycle, ub_re 16 cycles at 0x010..0x01F, res_we 16 cycles at 0x200..0x20F beginning 32 cycles after first ub_re, one done pulse.
REQ-023 Three tiles, w_base=3, WADDR_W=2 -> w_addr sequence 3,0,1; 48 res_we cycles; ub_addr contiguous over 48 rows.
REQ-024 tile_cnt=0 -> done pulses 2 cycles after start; no ub_re, we_rl or res_we.
REQ-025 Wrap: ub_base=0x3F8, res_base=0x3FC, tile_cnt=1 -> ub_addr 0x3F8..0x3FF,0x000..0x007; res_addr 0x3FC..0x3FF,0x000..0x00B.
REQ-026 start during STREAM -> ignored, err_busy=1, job completes unchanged; rst asserted during DRAIN -> all outputs 0 next cycle, no further res_we.
REQ-027 With TPU_SEQ_PERF_CNT_EN, single-tile job of REQ-022 -> cycle_cnt equals busy-cycle count and holds after done.
